// File: rtl/axi_sram_slave.sv
// AXI-lite style responder over a word-addressed 64-bit SRAM model.
// Independent read and write engines, each with a programmable response latency.
module axi_sram_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          MEM_DEPTH = 4096,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] axi_AW_ADDR,
  input  logic        axi_AW_VALID,
  output logic        axi_AW_READY,
  input  logic [63:0] axi_W_DATA,
  input  logic [7:0]  axi_W_STRB,
  input  logic        axi_W_VALID,
  output logic        axi_W_READY,
  output logic        axi_B_VALID,
  input  logic        axi_B_READY,
  input  logic [63:0] axi_AR_ADDR,
  input  logic        axi_AR_VALID,
  output logic        axi_AR_READY,
  output logic [63:0] axi_R_DATA,
  output logic        axi_R_VALID,
  input  logic        axi_R_READY
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(RD_LAT + WR_LAT + 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  function automatic logic [IDX_W-1:0] to_idx(input logic [63:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_w;
    for (int i = 0; i < 8; i++)
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  logic [63:0] mem [MEM_DEPTH];

  rd_state_t        rd_state, rd_state_nx;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nx;
  logic [IDX_W-1:0] rd_idx_p0, rd_idx_nx;
  logic             ar_ready, ar_ready_nx;
  logic             r_valid, r_valid_nx;
  logic [63:0]      r_data, r_data_nx;

  wr_state_t        wr_state, wr_state_nx;
  logic [CNT_W-1:0] wr_cnt, wr_cnt_nx;
  logic [IDX_W-1:0] wr_idx_p0, wr_idx_nx;
  logic [63:0]      wr_data_p0, wr_data_nx;
  logic [7:0]       wr_strb_p0, wr_strb_nx;
  logic             aw_ready, aw_ready_nx, w_ready, w_ready_nx;
  logic             aw_got, aw_got_nx, w_got, w_got_nx;
  logic             b_valid, b_valid_nx;

  logic             aw_hs, w_hs, wr_commit;
  logic [63:0]      rd_word;

  assign aw_hs     = axi_AW_VALID && aw_ready;
  assign w_hs      = axi_W_VALID && w_ready;
  assign wr_commit = (wr_state == W_WAIT) && (wr_cnt == '0);

  // a write landing on the same edge as the read sample is forwarded byte-wise
  assign rd_word = (wr_commit && (wr_idx_p0 == rd_idx_p0))
                 ? merge_bytes(mem[rd_idx_p0], wr_data_p0, wr_strb_p0)
                 : mem[rd_idx_p0];

  // Stage p0: request capture and latency countdown, read engine
  always_comb begin
    rd_state_nx = rd_state;
    rd_cnt_nx   = rd_cnt;
    rd_idx_nx   = rd_idx_p0;
    ar_ready_nx = ar_ready;
    r_valid_nx  = r_valid;
    r_data_nx   = r_data;
    case (rd_state)
      R_IDLE: begin
        ar_ready_nx = 1'b1;
        if (axi_AR_VALID && ar_ready) begin
          rd_idx_nx   = to_idx(axi_AR_ADDR);
          ar_ready_nx = 1'b0;
          rd_cnt_nx   = CNT_W'(RD_LAT - 1);
          rd_state_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt == '0) begin
          r_data_nx   = rd_word;
          r_valid_nx  = 1'b1;
          rd_state_nx = R_RESP;
        end else begin
          rd_cnt_nx = rd_cnt - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (axi_R_READY) begin
          r_valid_nx  = 1'b0;
          ar_ready_nx = 1'b1;
          rd_state_nx = R_IDLE;
        end
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  // Stage p0: address/data pairing and latency countdown, write engine
  always_comb begin
    wr_state_nx = wr_state;
    wr_cnt_nx   = wr_cnt;
    wr_idx_nx   = wr_idx_p0;
    wr_data_nx  = wr_data_p0;
    wr_strb_nx  = wr_strb_p0;
    aw_ready_nx = aw_ready;
    w_ready_nx  = w_ready;
    aw_got_nx   = aw_got;
    w_got_nx    = w_got;
    b_valid_nx  = b_valid;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs) begin
          wr_idx_nx   = to_idx(axi_AW_ADDR);
          aw_ready_nx = 1'b0;
          aw_got_nx   = 1'b1;
        end else if (!aw_got) begin
          aw_ready_nx = 1'b1;
        end
        if (w_hs) begin
          wr_data_nx = axi_W_DATA;
          wr_strb_nx = axi_W_STRB;
          w_ready_nx = 1'b0;
          w_got_nx   = 1'b1;
        end else if (!w_got) begin
          w_ready_nx = 1'b1;
        end
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          aw_ready_nx = 1'b0;
          w_ready_nx  = 1'b0;
          aw_got_nx   = 1'b0;
          w_got_nx    = 1'b0;
          wr_cnt_nx   = CNT_W'(WR_LAT - 1);
          wr_state_nx = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt == '0) begin
          b_valid_nx  = 1'b1;
          wr_state_nx = W_RESP;
        end else begin
          wr_cnt_nx = wr_cnt - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (axi_B_READY) begin
          b_valid_nx  = 1'b0;
          aw_ready_nx = 1'b1;
          w_ready_nx  = 1'b1;
          wr_state_nx = W_IDLE;
        end
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  // Stage p1: registered control and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      b_valid  <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      rd_cnt   <= rd_cnt_nx;
      ar_ready <= ar_ready_nx;
      r_valid  <= r_valid_nx;
      r_data   <= r_data_nx;
      wr_state <= wr_state_nx;
      wr_cnt   <= wr_cnt_nx;
      aw_ready <= aw_ready_nx;
      w_ready  <= w_ready_nx;
      aw_got   <= aw_got_nx;
      w_got    <= w_got_nx;
      b_valid  <= b_valid_nx;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p0  <= rd_idx_nx;
    wr_idx_p0  <= wr_idx_nx;
    wr_data_p0 <= wr_data_nx;
    wr_strb_p0 <= wr_strb_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_commit) mem[wr_idx_p0] <= merge_bytes(mem[wr_idx_p0], wr_data_p0, wr_strb_p0);
  end

  assign axi_AR_READY = ar_ready;
  assign axi_R_VALID  = r_valid;
  assign axi_R_DATA   = r_data;
  assign axi_AW_READY = aw_ready;
  assign axi_W_READY  = w_ready;
  assign axi_B_VALID  = b_valid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table, hand-written corner
// sequences, then randomized traffic against a word-array reference model.
module tb_axi_sram_slave;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          RDL   = 2;
  localparam int          WRL   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] axi_AW_ADDR;
  logic        axi_AW_VALID;
  logic        axi_AW_READY;
  logic [63:0] axi_W_DATA;
  logic [7:0]  axi_W_STRB;
  logic        axi_W_VALID;
  logic        axi_W_READY;
  logic        axi_B_VALID;
  logic        axi_B_READY;
  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY;
  logic [63:0] axi_R_DATA;
  logic        axi_R_VALID;
  logic        axi_R_READY;

  axi_sram_slave #(
    .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .RD_LAT(RDL), .WR_LAT(WRL)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
    .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
    .axi_W_READY(axi_W_READY), .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] ref_mem [int];

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          w_lead;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: handshake not completed within cycle budget", nm);
  endtask

  function automatic int model_idx(input logic [63:0] a);
    return int'(((a - BASE) / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] model_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                              input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++)
      if (strb[i]) mask = mask | (64'hFF << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int w_lead, input string nm);
    int aw_start, w_start, cyc, lat;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    axi_AW_ADDR = addr; axi_W_DATA = data; axi_W_STRB = strb;
    while (!(aw_done && w_done) && cyc < 64) begin
      axi_AW_VALID = !aw_done && (cyc >= aw_start);
      axi_W_VALID  = !w_done && (cyc >= w_start);
      aw_hs = axi_AW_VALID && axi_AW_READY;
      w_hs  = axi_W_VALID && axi_W_READY;
      @(negedge clk);
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail({nm, "_awhs"});
      return;
    end
    lat = 0;
    while (!axi_B_VALID && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_blat"}, 64'(lat), 64'(WRL));
    axi_B_READY = 1'b1;
    @(negedge clk);
    axi_B_READY = 1'b0;
    check({nm, "_bdone"}, {61'd0, axi_B_VALID, axi_AW_READY, axi_W_READY}, 64'b011);
  endtask

  // hold > 0: R_READY kept low for hold cycles while AR_VALID is offered.
  task automatic axi_read(input logic [63:0] addr, input int hold, input string nm,
                          output logic [63:0] data);
    int cyc, lat;
    bit done, hs;
    data = '0;
    axi_AR_ADDR = addr; axi_AR_VALID = 1'b1;
    done = 0; cyc = 0;
    while (!done && cyc < 64) begin
      hs = axi_AR_READY;
      @(negedge clk);
      done = hs;
      cyc++;
    end
    axi_AR_VALID = 1'b0;
    if (!done) begin
      timeout_fail({nm, "_arhs"});
      return;
    end
    lat = 0;
    while (!axi_R_VALID && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_rlat"}, 64'(lat), 64'(RDL));
    data = axi_R_DATA;
    for (int i = 0; i < hold; i++) begin
      axi_AR_VALID = 1'b1;
      axi_AR_ADDR  = addr ^ 64'h40;
      @(negedge clk);
      axi_AR_VALID = 1'b0;
      check({nm, "_hold_state"}, {62'd0, axi_R_VALID, axi_AR_READY}, 64'b10);
      check({nm, "_hold_data"}, axi_R_DATA, data);
    end
    axi_AR_ADDR = addr;
    axi_R_READY = 1'b1;
    @(negedge clk);
    axi_R_READY = 1'b0;
    check({nm, "_rdone"}, {62'd0, axi_R_VALID, axi_AR_READY}, 64'b01);
    if (hold > 0) begin
      repeat (RDL + 2) @(negedge clk);
      check({nm, "_no_phantom"}, 64'(axi_R_VALID), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [11];
    logic [63:0] rd, d, addr;
    logic [7:0]  s;
    int idx;

    vecs[0]  = '{1, BASE + 64'h10,   64'h1122334455667788, 8'hFF,  0, 64'h0};
    vecs[1]  = '{0, BASE + 64'h10,   64'h0, 8'h00,  0, 64'h1122334455667788};
    vecs[2]  = '{1, BASE + 64'h10,   64'hAAAAAAAABBBBBBBB, 8'h0F,  2, 64'h0};
    vecs[3]  = '{0, BASE + 64'h10,   64'h0, 8'h00,  0, 64'h11223344BBBBBBBB};
    vecs[4]  = '{1, BASE + 64'h10,   64'hFFFFFFFFFFFFFFFF, 8'h00, -1, 64'h0};
    vecs[5]  = '{0, BASE + 64'h10,   64'h0, 8'h00,  0, 64'h11223344BBBBBBBB};
    vecs[6]  = '{1, BASE,            64'hDEADBEEFCAFEF00D, 8'hFF,  0, 64'h0};
    vecs[7]  = '{0, BASE + 64'h8000, 64'h0, 8'h00,  0, 64'hDEADBEEFCAFEF00D};
    vecs[8]  = '{0, BASE + 64'h5,    64'h0, 8'h00,  0, 64'hDEADBEEFCAFEF00D};
    vecs[9]  = '{1, BASE + 64'h8018, 64'h0123456789ABCDEF, 8'hFF, -3, 64'h0};
    vecs[10] = '{0, BASE + 64'h18,   64'h0, 8'h00,  0, 64'h0123456789ABCDEF};

    rst = 1'b1;
    axi_AW_ADDR = '0; axi_AW_VALID = 1'b0; axi_W_DATA = '0; axi_W_STRB = '0;
    axi_W_VALID = 1'b0; axi_B_READY = 1'b0; axi_AR_ADDR = '0; axi_AR_VALID = 1'b0;
    axi_R_READY = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {59'd0, axi_AR_READY, axi_AW_READY, axi_W_READY, axi_B_VALID, axi_R_VALID}, 64'd0);
    check("reset_rdata", axi_R_DATA, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {59'd0, axi_AR_READY, axi_AW_READY, axi_W_READY, axi_B_VALID, axi_R_VALID}, 64'b11100);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].w_lead, $sformatf("vec%0d", i));
      end else begin
        axi_read(vecs[i].addr, 0, $sformatf("vec%0d", i), rd);
        check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      end
    end

    // R_READY stalled for 5 cycles with AR_VALID offered meanwhile
    axi_read(BASE + 64'h10, 5, "stall", rd);
    check("stall_data", rd, 64'h11223344BBBBBBBB);

    // write commit and read sample on the same edge, index 3
    axi_AR_ADDR = BASE + 64'h18; axi_AR_VALID = 1'b1;
    @(negedge clk);
    axi_AR_VALID = 1'b0;
    check("byp_ar_taken", 64'(axi_AR_READY), 64'd0);
    axi_AW_ADDR = BASE + 64'h18; axi_W_DATA = 64'hFEDCBA9876543210; axi_W_STRB = 8'hF0;
    axi_AW_VALID = 1'b1; axi_W_VALID = 1'b1;
    @(negedge clk);
    axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
    check("byp_aw_w_taken", {62'd0, axi_AW_READY, axi_W_READY}, 64'd0);
    @(negedge clk);
    check("byp_valids", {62'd0, axi_R_VALID, axi_B_VALID}, 64'b11);
    check("byp_rdata", axi_R_DATA, 64'hFEDCBA9889ABCDEF);
    axi_R_READY = 1'b1; axi_B_READY = 1'b1;
    @(negedge clk);
    axi_R_READY = 1'b0; axi_B_READY = 1'b0;
    axi_read(BASE + 64'h18, 0, "byp_after", rd);
    check("byp_after_data", rd, 64'hFEDCBA9889ABCDEF);

    // reset while both engines are waiting
    axi_write(BASE + 64'h28, 64'h5555555555555555, 8'hFF, 0, "pre5");
    axi_write(BASE + 64'h38, 64'h7777777777777777, 8'hFF, 0, "pre7");
    axi_AR_ADDR = BASE + 64'h38; axi_AR_VALID = 1'b1;
    axi_AW_ADDR = BASE + 64'h28; axi_W_DATA = 64'h0; axi_W_STRB = 8'hFF;
    axi_AW_VALID = 1'b1; axi_W_VALID = 1'b1;
    @(negedge clk);
    axi_AR_VALID = 1'b0; axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {59'd0, axi_AR_READY, axi_AW_READY, axi_W_READY, axi_B_VALID, axi_R_VALID}, 64'd0);
    check("midrst_rdata", axi_R_DATA, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", {59'd0, axi_AR_READY, axi_AW_READY, axi_W_READY, axi_B_VALID, axi_R_VALID}, 64'b11100);
    repeat (3) @(negedge clk);
    check("midrst_quiet", {62'd0, axi_B_VALID, axi_R_VALID}, 64'd0);
    axi_read(BASE + 64'h28, 0, "midrst_w", rd);
    check("midrst_w_data", rd, 64'h5555555555555555);
    axi_read(BASE + 64'h38, 0, "midrst_r", rd);
    check("midrst_r_data", rd, 64'h7777777777777777);

    // randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      axi_write(BASE + 64'(i) * 64'd8, d, 8'hFF, 0, "seed");
      ref_mem[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      idx  = $urandom_range(0, 15);
      addr = BASE + 64'(idx) * 64'd8 + 64'($urandom_range(0, 7))
           + 64'($urandom_range(0, 3)) * 64'd8 * 64'(DEPTH);
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        axi_write(addr, d, s, int'($urandom_range(0, 6)) - 3, $sformatf("rnd%0d", n));
        ref_mem[model_idx(addr)] = model_merge(ref_mem[model_idx(addr)], d, s);
      end else begin
        axi_read(addr, 0, $sformatf("rnd%0d", n), rd);
        check($sformatf("rnd%0d_data", n), rd, ref_mem[model_idx(addr)]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
